gpu2d_bg_tile_mem_arbiter: RTL and testbench
============================================

# gpu2d_bg_tile_mem_arbiter

Shares one background tile-memory simple-dual-port RAM (4096 x 96 bits, 16 x 6-bit colour indices per word) between the 2D renderer's tile-fetch stage and the host bus. The renderer has priority, but a starvation limit guarantees the host a slot. The block prevents same-cycle read/write address collisions, because the RAM leaves them undefined. It sits between the gpu2d renderer/host-bus adapters and the RAM instance and drives every RAM port.

## Interface
- ADDR_WIDTH, 12, RAM address width
- DATA_WIDTH, 96, RAM word width (16 colour indices x 6 bits)
- STARVE_LIMIT, 15, max consecutive render read grants while a host read waits; range 1..255
- clk  in  1  sole clock; all logic on rising edge
- reset  in  1  asynchronous, active-low (asserted when 0)
- io_rndReq_valid / io_rndReq_ready  in/out  1  renderer read request handshake
- io_rndReq_addr  in  ADDR_WIDTH  renderer read address
- io_rndRsp_valid  out  1  renderer read data valid; no backpressure
- io_rndRsp_data  out  DATA_WIDTH  renderer read data
- io_hostRd_valid / io_hostRd_ready  in/out  1  host read request handshake
- io_hostRd_addr  in  ADDR_WIDTH  host read address
- io_hostRsp_valid / io_hostRsp_ready  out/in  1  host read response handshake
- io_hostRsp_data  out  DATA_WIDTH  host read data
- io_hostWr_valid / io_hostWr_ready  in/out  1  host write handshake
- io_hostWr_addr  in  ADDR_WIDTH  host write address
- io_hostWr_data  in  DATA_WIDTH  host write data
- io_ram_wrEn, io_ram_wrAddr, io_ram_wrData  out  1/ADDR_WIDTH/DATA_WIDTH  RAM write port
- io_ram_rdEn, io_ram_rdAddr  out  1/ADDR_WIDTH  RAM read port
- io_ram_rdData  in  DATA_WIDTH  RAM registered read data, valid the cycle after rdEn

## Operation
- Write path is combinational. io_hostWr_ready = 1 whenever reset is deasserted. io_ram_wrEn = io_hostWr_valid. Address and data pass through unchanged.
- Collision rule: a read requester whose address equals io_hostWr_addr while io_hostWr_valid=1 is not eligible that cycle. It becomes eligible the next cycle, and the read returns the newly written data.
- Host eligibility also requires:
  - no host read in flight (hostInflight=0), and
  - the hold register empty, or being drained this cycle (io_hostRsp_valid & io_hostRsp_ready).
- Arbitration is evaluated each cycle over eligible requesters.
  - Only one eligible: it is granted.
  - Both eligible: host wins if starveCnt == STARVE_LIMIT, otherwise render wins.
  - Exactly one ready is asserted per cycle, combinationally.
- starveCnt (8 bits):
  - clears when a host read is granted or when io_hostRd_valid=0;
  - increments, saturating at STARVE_LIMIT, on a render grant while io_hostRd_valid=1.
  - Collision-blocked cycles neither increment nor clear it.
- Grant drives io_ram_rdEn=1 and io_ram_rdAddr=granted address; otherwise rdEn=0. rdAddr holds its last value.
- Render response: a registered rndInflight flag drives io_rndRsp_valid the cycle after grant, with io_rndRsp_data = io_ram_rdData.
- Host response:
  - hostInflight is set the cycle after a host grant.
  - In that cycle io_ram_rdData is captured into the hold register and holdValid is set.
  - io_hostRsp_valid = holdValid. holdValid clears on valid & ready, unless a capture occurs in the same cycle.
- Host responses are returned in request order; at most one host read is outstanding.

## Timing
- Reset (asynchronous, reset=0):
  - all registers clear: starveCnt=0, rndInflight=0, hostInflight=0, holdValid=0, hold data=0, rdAddr=0;
  - all valid/ready/enable outputs are 0, including io_hostWr_ready.
- Reset mid-transaction discards in-flight reads; no response is issued after reset releases.
- Render read latency: grant at cycle N -> io_rndRsp_valid at N+1.
- Host read latency: grant at N -> io_hostRsp_valid at N+2. Back-to-back host reads are possible at most every 2 cycles when the response is consumed immediately.
- Host write is accepted in the same cycle and is visible to a read granted at N+1 or later.
- Simultaneous render and host read with no collision: the render-priority and starvation rule applies; the write proceeds in parallel.
- Host response stall (io_hostRsp_ready=0): the hold register holds its data stable; new host reads are blocked; render reads are unaffected.

## Test plan
- Reset: hold reset=0 with all valids high -> every ready/valid/rdEn/wrEn output is 0. Release reset -> io_hostWr_ready=1 on the next edge.
- Render streaming: rndReq_valid=1, addrs 0..7 on consecutive cycles, host idle -> 8 grants, rndRsp_valid on cycles 1..8 with matching RAM words.
- Starvation: both requesters always valid, STARVE_LIMIT=3 -> grant pattern R,R,R,H repeating, with host responses at host-grant cycle +2.
- Collision: write addr 0x123 data A while render reads 0x123 -> rndReq_ready=0 that cycle. The next cycle it is granted, and rndRsp_data=A.
- Host backpressure: host read addr 0x010, hostRsp_ready=0 for 5 cycles -> hostRsp_valid steady with constant data, hostRd_ready=0 for a second request. Render grants continue. After ready=1, the response completes and the second host read is granted the same cycle.
- Async reset mid-flight: assert reset one cycle after a host grant -> no hostRsp_valid at any time after release.

Source files
------------

// File: rtl/gpu2d_bg_tile_mem_arbiter.sv
// rtl/gpu2d_bg_tile_mem_arbiter.sv - background tile RAM arbiter between renderer and host bus
//
// Purpose: owns every port of the background tile-memory simple-dual-port RAM.
// The host write path passes straight through. The single RAM read port is
// shared between the renderer tile fetch (priority) and host reads. A
// starvation counter guarantees the host a slot. A read that targets the
// address being written in the same cycle is held off one cycle, because the
// RAM leaves that case undefined.
//
// Ports:
//   clk, reset            clock; asynchronous active-low reset
//   io_rndReq_*           renderer read request (valid/ready/addr)
//   io_rndRsp_*           renderer read response (valid/data), no backpressure
//   io_hostRd_*           host read request (valid/ready/addr)
//   io_hostRsp_*          host read response (valid/ready/data)
//   io_hostWr_*           host write (valid/ready/addr/data)
//   io_ram_wr*            RAM write port
//   io_ram_rd*            RAM read port; rdData is registered, valid the cycle after rdEn
module gpu2d_bg_tile_mem_arbiter #(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 96,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  io_rndReq_valid,
  output logic                  io_rndReq_ready,
  input  logic [ADDR_WIDTH-1:0] io_rndReq_addr,
  output logic                  io_rndRsp_valid,
  output logic [DATA_WIDTH-1:0] io_rndRsp_data,
  input  logic                  io_hostRd_valid,
  output logic                  io_hostRd_ready,
  input  logic [ADDR_WIDTH-1:0] io_hostRd_addr,
  output logic                  io_hostRsp_valid,
  input  logic                  io_hostRsp_ready,
  output logic [DATA_WIDTH-1:0] io_hostRsp_data,
  input  logic                  io_hostWr_valid,
  output logic                  io_hostWr_ready,
  input  logic [ADDR_WIDTH-1:0] io_hostWr_addr,
  input  logic [DATA_WIDTH-1:0] io_hostWr_data,
  output logic                  io_ram_wrEn,
  output logic [ADDR_WIDTH-1:0] io_ram_wrAddr,
  output logic [DATA_WIDTH-1:0] io_ram_wrData,
  output logic                  io_ram_rdEn,
  output logic [ADDR_WIDTH-1:0] io_ram_rdAddr,
  input  logic [DATA_WIDTH-1:0] io_ram_rdData
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0]            starve_cnt;
  logic                  rnd_inflight;
  logic                  host_inflight;
  logic                  hold_valid;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [ADDR_WIDTH-1:0] rd_addr_q;

  logic wr_active;
  logic hold_drain;
  logic rnd_elig;
  logic host_elig;
  logic grant_rnd;
  logic grant_host;

  always_comb begin
    // Everything is gated by reset so that all handshakes read 0 while held.
    wr_active  = reset && io_hostWr_valid;
    hold_drain = hold_valid && io_hostRsp_ready;
    rnd_elig   = reset && io_rndReq_valid &&
                 !(wr_active && (io_rndReq_addr == io_hostWr_addr));
    // One host read outstanding at most: the hold register must be free (or
    // freeing now) and no RAM read for the host may still be in the pipe.
    host_elig  = reset && io_hostRd_valid &&
                 !(wr_active && (io_hostRd_addr == io_hostWr_addr)) &&
                 !host_inflight && (!hold_valid || hold_drain);
    grant_host = host_elig && (!rnd_elig || (starve_cnt == LIMIT));
    grant_rnd  = rnd_elig && !grant_host;
  end

  assign io_hostWr_ready  = reset;
  assign io_ram_wrEn      = wr_active;
  assign io_ram_wrAddr    = io_hostWr_addr;
  assign io_ram_wrData    = io_hostWr_data;

  assign io_rndReq_ready  = grant_rnd;
  assign io_hostRd_ready  = grant_host;
  assign io_ram_rdEn      = grant_rnd || grant_host;
  assign io_ram_rdAddr    = grant_host ? io_hostRd_addr :
                            grant_rnd  ? io_rndReq_addr : rd_addr_q;

  assign io_rndRsp_valid  = rnd_inflight;
  assign io_rndRsp_data   = io_ram_rdData;
  assign io_hostRsp_valid = hold_valid;
  assign io_hostRsp_data  = hold_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt    <= 8'd0;
      rnd_inflight  <= 1'b0;
      host_inflight <= 1'b0;
      hold_valid    <= 1'b0;
      hold_data     <= '0;
      rd_addr_q     <= '0;
    end else begin
      rnd_inflight  <= grant_rnd;
      host_inflight <= grant_host;
      if (grant_rnd || grant_host) begin
        rd_addr_q <= io_ram_rdAddr;
      end
      // Collision-blocked or otherwise idle cycles leave the count untouched.
      if (grant_host || !io_hostRd_valid) begin
        starve_cnt <= 8'd0;
      end else if (grant_rnd && (starve_cnt < LIMIT)) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
      // A capture always wins over a drain in the same cycle.
      if (host_inflight) begin
        hold_valid <= 1'b1;
        hold_data  <= io_ram_rdData;
      end else if (hold_drain) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gpu2d_bg_tile_mem_arbiter.sv
// tb/tb_gpu2d_bg_tile_mem_arbiter.sv - self-checking bench for gpu2d_bg_tile_mem_arbiter
module tb_gpu2d_bg_tile_mem_arbiter;

  localparam int AW = 12;
  localparam int DW = 96;
  localparam int SL = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic rv, hv, wv, hr;
  logic [AW-1:0] ra, ha, wa;
  logic [DW-1:0] wd;

  logic rnd_ready, rnd_rsp_valid, host_ready, host_rsp_valid, wr_ready;
  logic [DW-1:0] rnd_rsp_data, host_rsp_data;
  logic ram_wr_en, ram_rd_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;

  always #5 clk = ~clk;

  gpu2d_bg_tile_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .reset(rst_n),
    .io_rndReq_valid(rv), .io_rndReq_ready(rnd_ready), .io_rndReq_addr(ra),
    .io_rndRsp_valid(rnd_rsp_valid), .io_rndRsp_data(rnd_rsp_data),
    .io_hostRd_valid(hv), .io_hostRd_ready(host_ready), .io_hostRd_addr(ha),
    .io_hostRsp_valid(host_rsp_valid), .io_hostRsp_ready(hr),
    .io_hostRsp_data(host_rsp_data),
    .io_hostWr_valid(wv), .io_hostWr_ready(wr_ready), .io_hostWr_addr(wa),
    .io_hostWr_data(wd),
    .io_ram_wrEn(ram_wr_en), .io_ram_wrAddr(ram_wr_addr), .io_ram_wrData(ram_wr_data),
    .io_ram_rdEn(ram_rd_en), .io_ram_rdAddr(ram_rd_addr), .io_ram_rdData(ram_rd_data)
  );

  // Environment RAM driven by the DUT's RAM ports.
  logic [DW-1:0] ram [0:4095];
  always @(posedge clk) begin
    if (ram_rd_en) ram_rd_data <= ram[ram_rd_addr];
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: golden memory from the bench's own writes, and queues of
  // expected responses tagged with the cycle they must appear in.
  typedef struct packed { logic [DW-1:0] d; int due; } exp_t;
  logic [DW-1:0] gmem [0:4095];
  exp_t rq[$];
  exp_t hq[$];
  int cyc = 0;
  int streak = 0;
  logic [AW-1:0] last_addr = '0;

  always @(negedge clk) begin : model
    logic r_el, h_el, h_vis, gr, gh, e_rv;
    logic [AW-1:0] e_addr;
    cyc++;
    if (!rst_n) begin
      chk("rst_rnd_ready", rnd_ready, 0);
      chk("rst_host_ready", host_ready, 0);
      chk("rst_wr_ready", wr_ready, 0);
      chk("rst_wr_en", ram_wr_en, 0);
      chk("rst_rd_en", ram_rd_en, 0);
      chk("rst_rnd_rsp_valid", rnd_rsp_valid, 0);
      chk("rst_host_rsp_valid", host_rsp_valid, 0);
      chk("rst_rd_addr", ram_rd_addr, 0);
      rq.delete();
      hq.delete();
      streak = 0;
      last_addr = '0;
    end else begin
      r_el  = rv && !(wv && ra == wa);
      h_vis = hq.size() > 0 && hq[0].due <= cyc;
      h_el  = hv && !(wv && ha == wa) && (hq.size() == 0 || (h_vis && hr));
      gh    = h_el && (!r_el || streak == SL);
      gr    = r_el && !gh;
      e_addr = gh ? ha : (gr ? ra : last_addr);

      chk("wr_ready", wr_ready, 1);
      chk("wr_en", ram_wr_en, wv);
      if (wv) begin
        chk("wr_addr", ram_wr_addr, wa);
        chk("wr_data", ram_wr_data, wd);
      end
      chk("rnd_ready", rnd_ready, gr);
      chk("host_ready", host_ready, gh);
      chk("rd_en", ram_rd_en, gr || gh);
      chk("rd_addr", ram_rd_addr, e_addr);

      e_rv = rq.size() > 0 && rq[0].due <= cyc;
      chk("rnd_rsp_valid", rnd_rsp_valid, e_rv);
      if (e_rv) begin
        chk("rnd_rsp_data", rnd_rsp_data, rq[0].d);
        void'(rq.pop_front());
      end
      chk("host_rsp_valid", host_rsp_valid, h_vis);
      if (h_vis) begin
        chk("host_rsp_data", host_rsp_data, hq[0].d);
        if (hr) void'(hq.pop_front());
      end

      if (gr) rq.push_back('{d: gmem[ra], due: cyc + 1});
      if (gh) hq.push_back('{d: gmem[ha], due: cyc + 2});
      if (gh || !hv) streak = 0;
      else if (gr && streak < SL) streak++;
      last_addr = e_addr;
      if (wv) gmem[wa] = wd;
    end
  end

  task automatic drive(input logic r_v, input logic [AW-1:0] r_a,
                       input logic h_v, input logic [AW-1:0] h_a,
                       input logic w_v, input logic [AW-1:0] w_a,
                       input logic [DW-1:0] w_d, input logic h_r, input logic rs);
    @(posedge clk);
    #1;
    rv = r_v; ra = r_a; hv = h_v; ha = h_a;
    wv = w_v; wa = w_a; wd = w_d; hr = h_r; rst_n = rs;
    @(negedge clk);
  endtask

  function automatic logic [DW-1:0] lit(input int k);
    return 96'hA5A5_0000_0000_0000_0000_0000 | DW'(k);
  endfunction

  localparam logic [DW-1:0] DATA_A = 96'hDEAD_BEEF_0123_4567_89AB_CDEF;
  localparam logic [DW-1:0] DATA_B = 96'h0000_0010_CAFE_F00D_1234_5678;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] pat;
    int cnt;
    for (int i = 0; i < 4096; i++) begin
      ram[i]  = {$urandom, $urandom, $urandom};
      gmem[i] = ram[i];
    end
    rst_n = 1'b0; rv = 1; hv = 1; wv = 1; hr = 1;
    ra = 12'h001; ha = 12'h002; wa = 12'h003; wd = '1;

    // Reset held with every valid high.
    repeat (3) @(negedge clk);
    chk("lit_rst_rnd_ready", rnd_ready, 0);
    chk("lit_rst_host_ready", host_ready, 0);
    chk("lit_rst_wr_ready", wr_ready, 0);
    chk("lit_rst_wr_en", ram_wr_en, 0);
    chk("lit_rst_rd_en", ram_rd_en, 0);
    chk("lit_rst_host_rsp_valid", host_rsp_valid, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("lit_wr_ready_after_rst", wr_ready, 1);

    // Preload known words.
    for (int k = 0; k < 8; k++) drive(0, 0, 0, 0, 1, AW'(k), lit(k), 1, 1);
    drive(0, 0, 0, 0, 1, 12'h010, DATA_B, 1, 1);

    // Render streaming.
    for (int k = 0; k < 8; k++) begin
      drive(1, AW'(k), 0, 0, 0, 0, 0, 1, 1);
      chk("lit_stream_ready", rnd_ready, 1);
      if (k > 0) begin
        chk("lit_stream_valid", rnd_rsp_valid, 1);
        chk("lit_stream_data", rnd_rsp_data, lit(k - 1));
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("lit_stream_last_data", rnd_rsp_data, lit(7));
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);

    // Starvation: R,R,R,H repeating with limit 3.
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      drive(1, AW'(100 + i), 1, AW'(200 + i), 0, 0, 0, 1, 1);
      pat = {pat[6:0], host_ready};
    end
    chk("lit_starve_pattern", pat, 8'b0001_0001);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 1, 1);

    // Collision.
    drive(1, 12'h123, 0, 0, 1, 12'h123, DATA_A, 1, 1);
    chk("lit_coll_blocked", rnd_ready, 0);
    drive(1, 12'h123, 0, 0, 0, 0, 0, 1, 1);
    chk("lit_coll_granted", rnd_ready, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    chk("lit_coll_rsp_valid", rnd_rsp_valid, 1);
    chk("lit_coll_rsp_data", rnd_rsp_data, DATA_A);

    // Host backpressure.
    drive(0, 0, 1, 12'h010, 0, 0, 0, 0, 1);
    chk("lit_bp_grant", host_ready, 1);
    for (int i = 0; i < 6; i++) begin
      drive(1, AW'(48 + i), 1, 12'h020, 0, 0, 0, 0, 1);
      chk("lit_bp_host_blocked", host_ready, 0);
      chk("lit_bp_rnd_runs", rnd_ready, 1);
      if (i > 0) begin
        chk("lit_bp_valid", host_rsp_valid, 1);
        chk("lit_bp_data", host_rsp_data, DATA_B);
      end
    end
    drive(0, 0, 1, 12'h020, 0, 0, 0, 1, 1);
    chk("lit_bp_release_valid", host_rsp_valid, 1);
    chk("lit_bp_second_grant", host_ready, 1);
    repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 1, 1);

    // Reset one cycle after a host grant.
    drive(0, 0, 1, 12'h040, 0, 0, 0, 1, 1);
    chk("lit_rst_mid_grant", host_ready, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
      if (host_rsp_valid) cnt++;
    end
    chk("lit_rst_mid_no_rsp", cnt, 0);

    // Randomized traffic, addresses packed into a small window to force collisions.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 7, AW'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)),
            $urandom_range(0, 9) < 3, AW'($urandom_range(0, 15)),
            {$urandom, $urandom, $urandom},
            $urandom_range(0, 9) < 7, $urandom_range(0, 399) != 0);
    end
    repeat (4) drive(0, 0, 0, 0, 0, 0, 0, 1, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
